// File: rtl/lsu_dmem_ctrl_if.sv
// Bundle for the LSU request/response handshake and the dmem write/read ports.
// The slave modport is the controller's view; the master modport is the pipeline/memory side.
interface lsu_dmem_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 13
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [DW-1:0] req_wdata;
    logic [4:0]    req_rd;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic [4:0]    rsp_rd;
    logic          rsp_err;
    logic          data_wena;
    logic [3:0]    data_wbe;
    logic [AW-1:0] data_waddra;
    logic [DW-1:0] data_dina;
    logic [AW-1:0] addrb;
    logic [DW-1:0] dout_b;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, dout_b,
        output req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        output data_wena, data_wbe, data_waddra, data_dina, addrb
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, req_rd, rsp_ready, dout_b,
        input  req_ready, rsp_valid, rsp_rdata, rsp_rd, rsp_err,
        input  data_wena, data_wbe, data_waddra, data_dina, addrb
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// RV32I load/store controller driving a dmem with one write port and a 1-cycle-latency read port.
// One request is outstanding at a time; responses carry aligned, extended load data.
module lsu_dmem_ctrl #(
    parameter int INSTR_WIDTH = 32,
    parameter int MEM_DEPTH   = 4096,
    parameter int MEM_DEPTH_W = $clog2(MEM_DEPTH + 1)
) (
    input logic            clk,
    input logic            rst,
    lsu_dmem_ctrl_if.slave bus
);
    localparam int DW = INSTR_WIDTH;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        LD_A = 3'd2,
        LD_D = 3'd3,
        RSP  = 3'd4
    } state_t;

    state_t                 state_r, state_s;
    logic                   rsp_valid_r, rsp_valid_s;
    logic [DW-1:0]          rsp_rdata_r, rsp_rdata_s;
    logic [4:0]             rsp_rd_r, rsp_rd_s;
    logic                   rsp_err_r, rsp_err_s;
    logic                   wena_r, wena_s;
    logic [3:0]             wbe_r, wbe_s;
    logic [MEM_DEPTH_W-1:0] waddra_r, waddra_s;
    logic [DW-1:0]          dina_r, dina_s;
    logic [MEM_DEPTH_W-1:0] addrb_r, addrb_s;
    logic [2:0]             f3_r, f3_s;
    logic [1:0]             off_r, off_s;
    logic [MEM_DEPTH_W-1:0] word_addr_s;
    logic                   req_err_s;
    logic                   unused_addr_s;

    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        case (f3)
            3'b000:          e = 1'b0;
            3'b001:          e = off[0];
            3'b010:          e = (off != 2'b00);
            3'b100, 3'b101:  e = we;
            default:         e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [DW-1:0] store_data(input logic [2:0] f3, input logic [DW-1:0] wd);
        logic [DW-1:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [DW-1:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                   input logic [DW-1:0] dout);
        logic [7:0]    b;
        logic [15:0]   h;
        logic [DW-1:0] r;
        b = dout[{off, 3'b000} +: 8];
        h = dout[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = dout;
            default: r = {DW{1'b0}};
        endcase
        return r;
    endfunction

    // Upper address bits are deliberately ignored: the word address wraps within dmem.
    assign word_addr_s   = bus.req_addr[MEM_DEPTH_W+1:2];
    assign unused_addr_s = ^bus.req_addr[31:MEM_DEPTH_W+2];
    assign req_err_s     = access_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_s     = state_r;
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_rd_s    = rsp_rd_r;
        rsp_err_s   = rsp_err_r;
        wena_s      = 1'b0;
        wbe_s       = wbe_r;
        waddra_s    = waddra_r;
        dina_s      = dina_r;
        addrb_s     = addrb_r;
        f3_s        = f3_r;
        off_s       = off_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    rsp_rd_s    = bus.req_rd;
                    rsp_rdata_s = {DW{1'b0}};
                    f3_s        = bus.req_funct3;
                    off_s       = bus.req_addr[1:0];
                    if (req_err_s) begin
                        rsp_err_s   = 1'b1;
                        rsp_valid_s = 1'b1;
                        state_s     = RSP;
                    end else if (bus.req_we) begin
                        rsp_err_s = 1'b0;
                        wena_s    = 1'b1;
                        wbe_s     = store_be(bus.req_funct3, bus.req_addr[1:0]);
                        waddra_s  = word_addr_s;
                        dina_s    = store_data(bus.req_funct3, bus.req_wdata);
                        state_s   = WR;
                    end else begin
                        rsp_err_s = 1'b0;
                        addrb_s   = word_addr_s;
                        state_s   = LD_A;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WR: begin
                rsp_valid_s = 1'b1;
                state_s     = RSP;
            end
            LD_A: begin
                state_s = LD_D;
            end
            LD_D: begin
                rsp_rdata_s = load_extract(f3_r, off_r, bus.dout_b);
                rsp_valid_s = 1'b1;
                state_s     = RSP;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                rsp_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs and captured request attributes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DW{1'b0}};
            rsp_rd_r    <= 5'd0;
            rsp_err_r   <= 1'b0;
            wena_r      <= 1'b0;
            wbe_r       <= 4'd0;
            waddra_r    <= {MEM_DEPTH_W{1'b0}};
            dina_r      <= {DW{1'b0}};
            addrb_r     <= {MEM_DEPTH_W{1'b0}};
            f3_r        <= 3'd0;
            off_r       <= 2'd0;
        end else begin
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_rd_r    <= rsp_rd_s;
            rsp_err_r   <= rsp_err_s;
            wena_r      <= wena_s;
            wbe_r       <= wbe_s;
            waddra_r    <= waddra_s;
            dina_r      <= dina_s;
            addrb_r     <= addrb_s;
            f3_r        <= f3_s;
            off_r       <= off_s;
        end
    end

    assign bus.req_ready   = (state_r == IDLE);
    assign bus.rsp_valid   = rsp_valid_r;
    assign bus.rsp_rdata   = rsp_rdata_r;
    assign bus.rsp_rd      = rsp_rd_r;
    assign bus.rsp_err     = rsp_err_r;
    assign bus.data_wena   = wena_r;
    assign bus.data_wbe    = wbe_r;
    assign bus.data_waddra = waddra_r;
    assign bus.data_dina   = dina_r;
    assign bus.addrb       = addrb_r;
endmodule
